// File: rtl/plic_pkg.sv
// Shared definitions for the lightweight platform interrupt controller:
// register offsets and the per-source gateway states.
package plic_pkg;

  localparam logic [21:0] PRIO_BASE   = 22'h000000;
  localparam logic [21:0] PENDING_OFF = 22'h001000;
  localparam logic [21:0] ENABLE_OFF  = 22'h002000;
  localparam logic [21:0] THRESH_OFF  = 22'h200000;
  localparam logic [21:0] CLAIM_OFF   = 22'h200004;

  typedef enum logic [1:0] {
    GW_IDLE,
    GW_PENDING,
    GW_IN_SERVICE
  } gateway_state_e;

endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: latches a level request, and holds it off from
// re-pending until software completes the claimed interrupt.
module plic_gateway
  import plic_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic claim,
  input  logic complete,
  output logic pending
);

  gateway_state_e state_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= GW_IDLE;
      pending   <= 1'b0;
    end else begin
      case (state_reg)
        GW_IDLE: begin
          if (irq) begin
            state_reg <= GW_PENDING;
            pending   <= 1'b1;
          end
        end
        GW_PENDING: begin
          if (claim) begin
            state_reg <= GW_IN_SERVICE;
            pending   <= 1'b0;
          end
        end
        GW_IN_SERVICE: begin
          if (complete) state_reg <= GW_IDLE;
        end
        default: begin
          state_reg <= GW_IDLE;
          pending   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/plic_lite.sv
// Platform-level external interrupt controller: priority/enable/threshold
// filtering, claim/complete bus handshake and a registered int_m_ext.
module plic_lite
  import plic_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               bus_req,
  input  logic               bus_we,
  input  logic [21:0]        bus_addr,
  input  logic [31:0]        bus_wdata,
  output logic               bus_rsp,
  output logic [31:0]        bus_rdata,
  output logic               bus_err,
  output logic               int_m_ext
);

  localparam logic [9:0] MAX_PRIO_ID = 10'(NUM_SRC);

  logic [PRIO_W-1:0]  prio_reg [1:NUM_SRC];
  logic [NUM_SRC:1]   enable_reg;
  logic [PRIO_W-1:0]  thresh_reg;

  logic [NUM_SRC:1]   pending;
  logic [NUM_SRC:1]   eligible;
  logic [NUM_SRC:1]   claim_vec;
  logic [NUM_SRC:1]   complete_vec;
  logic [NUM_SRC:1]   prio_we;
  logic               enable_we;
  logic               thresh_we;
  logic [4:0]         best_id;
  logic [PRIO_W-1:0]  best_prio;
  logic [31:0]        pend_word;
  logic [31:0]        en_word;
  logic [31:0]        rdata_next;
  logic               err_next;

  logic [19:0] word;
  logic [9:0]  prio_id;
  logic        is_prio;
  logic        unused_bits;

  assign word        = bus_addr[21:2];
  assign prio_id     = word[9:0];
  assign is_prio     = (word[19:10] == PRIO_BASE[21:12]);
  assign unused_bits = ^{bus_addr[1:0], bus_wdata};

  generate
    for (genvar gi = 1; gi <= NUM_SRC; gi++) begin : g_gw
      plic_gateway u_gw (
        .clk      (clk),
        .rst      (rst),
        .irq      (src_irq[gi-1]),
        .claim    (claim_vec[gi]),
        .complete (complete_vec[gi]),
        .pending  (pending[gi])
      );
    end
  endgenerate

  // Strict '>' keeps the lowest ID on priority ties.
  always_comb begin
    eligible  = '0;
    best_id   = '0;
    best_prio = '0;
    pend_word = '0;
    en_word   = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      eligible[i]  = pending[i] && enable_reg[i] && (prio_reg[i] > thresh_reg);
      pend_word[i] = pending[i];
      en_word[i]   = enable_reg[i];
      if (eligible[i] && (prio_reg[i] > best_prio)) begin
        best_prio = prio_reg[i];
        best_id   = 5'(i);
      end
    end
  end

  always_comb begin
    rdata_next   = '0;
    err_next     = 1'b0;
    prio_we      = '0;
    enable_we    = 1'b0;
    thresh_we    = 1'b0;
    claim_vec    = '0;
    complete_vec = '0;
    if (bus_req) begin
      if (is_prio) begin
        if (prio_id > MAX_PRIO_ID) begin
          err_next = 1'b1;
        end else begin
          for (int i = 1; i <= NUM_SRC; i++) begin
            if (prio_id == 10'(i)) begin
              if (bus_we) prio_we[i] = 1'b1;
              else        rdata_next = 32'(prio_reg[i]);
            end
          end
        end
      end else if (word == PENDING_OFF[21:2]) begin
        if (!bus_we) rdata_next = pend_word;
      end else if (word == ENABLE_OFF[21:2]) begin
        if (bus_we) enable_we = 1'b1;
        else        rdata_next = en_word;
      end else if (word == THRESH_OFF[21:2]) begin
        if (bus_we) thresh_we = 1'b1;
        else        rdata_next = 32'(thresh_reg);
      end else if (word == CLAIM_OFF[21:2]) begin
        for (int i = 1; i <= NUM_SRC; i++) begin
          if (bus_we) complete_vec[i] = (bus_wdata[4:0] == 5'(i));
          else        claim_vec[i]    = (best_id == 5'(i));
        end
        if (!bus_we) rdata_next = 32'(best_id);
      end else begin
        err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= NUM_SRC; i++) prio_reg[i] <= '0;
      enable_reg <= '0;
      thresh_reg <= '0;
      bus_rsp    <= 1'b0;
      bus_rdata  <= '0;
      bus_err    <= 1'b0;
      int_m_ext  <= 1'b0;
    end else begin
      for (int i = 1; i <= NUM_SRC; i++) begin
        if (prio_we[i]) prio_reg[i] <= bus_wdata[PRIO_W-1:0];
      end
      if (enable_we) enable_reg <= bus_wdata[NUM_SRC:1];
      if (thresh_we) thresh_reg <= bus_wdata[PRIO_W-1:0];
      bus_rsp   <= bus_req;
      bus_rdata <= rdata_next;
      bus_err   <= err_next;
      int_m_ext <= |eligible;
    end
  end

endmodule
